// File: rtl/fetch_ifid.sv
// Fetch stage: PC register, next-PC select and IF/ID register.
// Define FETCH_PERF_EN to build the hold/flush counters.
module fetch_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PChold,
  input  logic             IFIDhold,
  input  logic             branchID,
  input  logic [31:0]      branchTarget,
  input  logic             jumpID,
  input  logic [31:0]      jumpTarget,
  output logic [31:0]      pcIF,
  input  logic [31:0]      instrIF,
  output logic [31:0]      instrID,
  output logic [31:0]      pc4ID,
  output logic             validID,
  output logic [CNT_W-1:0] holdCnt,
  output logic [CNT_W-1:0] flushCnt
);

  logic [31:0] pc_q, pc_d, pc4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4id_q, pc4id_d;
  logic        valid_q, valid_d;
  logic        redirect;

  assign pc4      = pc_q + 32'd4;
  assign redirect = (jumpID | branchID) & ~PChold;

  // Hold outranks redirect: ID re-presents the branch next cycle.
  always_comb begin
    pc_d = pc4;
    if (PChold)
      pc_d = pc_q;
    else if (jumpID)
      pc_d = {jumpTarget[31:2], 2'b00};
    else if (branchID)
      pc_d = {branchTarget[31:2], 2'b00};
  end

  always_comb begin
    instr_d = instrIF;
    pc4id_d = pc4;
    valid_d = 1'b1;
    if (IFIDhold) begin
      instr_d = instr_q;
      pc4id_d = pc4id_q;
      valid_d = valid_q;
    end else if (redirect) begin
      instr_d = NOP_INSTR;
      pc4id_d = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4id_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4id_q <= pc4id_d;
      valid_q <= valid_d;
    end
  end

  assign pcIF    = pc_q;
  assign instrID = instr_q;
  assign pc4ID   = pc4id_q;
  assign validID = valid_q;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating: stick at all-ones until reset.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PChold && (hold_cnt_q != '1))
      hold_cnt_d = hold_cnt_q + 1'b1;
    if (redirect && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign holdCnt  = hold_cnt_q;
  assign flushCnt = flush_cnt_q;
`else
  assign holdCnt  = '0;
  assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed-vector bench for fetch_ifid.
// Counter expectations follow FETCH_PERF_EN.
module tb_fetch_ifid;

  localparam int CW = 4;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          PChold = 1'b0;
  logic          IFIDhold = 1'b0;
  logic          branchID = 1'b0;
  logic [31:0]   branchTarget = '0;
  logic          jumpID = 1'b0;
  logic [31:0]   jumpTarget = '0;
  logic [31:0]   pcIF, instrIF, instrID, pc4ID;
  logic          validID;
  logic [CW-1:0] holdCnt, flushCnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  assign instrIF = mem(pcIF);

  fetch_ifid #(
    .RESET_PC (32'h0),
    .NOP_INSTR(32'h0),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PChold      (PChold),
    .IFIDhold    (IFIDhold),
    .branchID    (branchID),
    .branchTarget(branchTarget),
    .jumpID      (jumpID),
    .jumpTarget  (jumpTarget),
    .pcIF        (pcIF),
    .instrIF     (instrIF),
    .instrID     (instrID),
    .pc4ID       (pc4ID),
    .validID     (validID),
    .holdCnt     (holdCnt),
    .flushCnt    (flushCnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ec(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag,
                    input logic [31:0] pc,
                    input logic [31:0] ins,
                    input logic [31:0] p4,
                    input logic v);
    chk({tag, ".pc"}, pcIF, pc);
    chk({tag, ".ins"}, instrID, ins);
    chk({tag, ".pc4"}, pc4ID, p4);
    chk({tag, ".v"}, {31'd0, validID}, {31'd0, v});
  endtask

  task automatic cnt(input string tag,
                     input int h, input int f);
    chk({tag, ".hc"}, {28'd0, holdCnt}, ec(h));
    chk({tag, ".fc"}, {28'd0, flushCnt}, ec(f));
  endtask

  task automatic hold(input logic h);
    PChold   = h;
    IFIDhold = h;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    st("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    cnt("rst", 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("seq0.pc", pcIF, 32'h0);
    cyc(); st("seq1", 32'h4, mem(32'h0), 32'h4, 1'b1);
    cyc(); st("seq2", 32'h8, mem(32'h4), 32'h8, 1'b1);
    hold(1'b1);
    cyc(); st("hld", 32'h8, mem(32'h4), 32'h8, 1'b1);
    cnt("hld", 1, 0);
    hold(1'b0);
    cyc(); st("seq3", 32'hC, mem(32'h8), 32'hC, 1'b1);
    branchID = 1'b1;
    branchTarget = 32'h40;
    cyc(); st("br", 32'h40, 32'h0, 32'h0, 1'b0);
    cnt("br", 1, 1);
    branchID = 1'b0;
    cyc(); st("brt", 32'h44, mem(32'h40), 32'h44, 1'b1);
    jumpID = 1'b1;
    jumpTarget = 32'h103;
    hold(1'b1);
    cyc(); st("hj", 32'h44, mem(32'h40), 32'h44, 1'b1);
    cnt("hj", 2, 1);
    hold(1'b0);
    cyc(); st("jmp", 32'h100, 32'h0, 32'h0, 1'b0);
    cnt("jmp", 2, 2);
    jumpID = 1'b0;
    cyc(); st("jt", 32'h104, mem(32'h100), 32'h104, 1'b1);
    jumpID = 1'b1;
    jumpTarget = 32'hFFFF_FFFF;
    cyc(); st("top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    jumpID = 1'b0;
    cyc();
    st("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);
    branchID = 1'b1;
    branchTarget = 32'h200;
    jumpID = 1'b1;
    jumpTarget = 32'h300;
    cyc(); st("pri", 32'h300, 32'h0, 32'h0, 1'b0);
    cnt("pri", 2, 4);
    branchID = 1'b0;
    jumpID = 1'b0;
    cyc(); st("prt", 32'h304, mem(32'h300), 32'h304, 1'b1);
    hold(1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("sat.pc", pcIF, 32'h304);
      chk("sat.hc", {28'd0, holdCnt},
          ec((3 + i > 15) ? 15 : 3 + i));
    end
    st("sat", 32'h304, mem(32'h300), 32'h304, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    st("arst", 32'h0, 32'h0, 32'h0, 1'b0);
    cnt("arst", 0, 0);
    hold(1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(); st("post", 32'h4, mem(32'h0), 32'h4, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_ifid.md
# fetch_ifid

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU. It owns the program counter, selects the next PC from sequential, branch and jump sources, and presents the fetched instruction to the decode stage. It consumes the `PChold`/`IFIDhold` stall from the load-use hazard unit and flushes the IF/ID slot on a control-flow redirect resolved in ID.

## Interface
- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset.
- `NOP_INSTR`, `32'h0000_0000`: bubble instruction inserted on flush and reset.
- `CNT_W`, `16`: width of the performance counters.

- `clk`  input  1  pipeline clock, rising-edge active.
- `reset`  input  1  asynchronous, active-high reset.
- `PChold`  input  1  freeze the PC register this cycle (load-use stall).
- `IFIDhold`  input  1  freeze the IF/ID register this cycle.
- `branchID`  input  1  branch in ID resolved taken.
- `branchTarget`  input  32  branch target from ID.
- `jumpID`  input  1  jump (j/jal/jr) in ID.
- `jumpTarget`  input  32  jump target from ID.
- `pcIF`  output  32  current PC, drives the instruction memory address.
- `instrIF`  input  32  instruction memory read data (combinational on `pcIF`).
- `instrID`  output  32  registered instruction for decode.
- `pc4ID`  output  32  registered PC+4 of `instrID` (link address, branch base).
- `validID`  output  1  `instrID` is a real instruction, not a bubble.
- `holdCnt`  output  CNT_W  cycles with `PChold` asserted.
- `flushCnt`  output  CNT_W  redirects taken.

## Operation
- Next-PC priority: `reset` > hold > jump > branch > PC+4.
- Redirect = (`jumpID` or `branchID`) and not `PChold`. When hold is asserted, the redirect is ignored; ID re-presents the branch/jump next cycle.
- Jump wins over branch when both are asserted.
- Targets have bits [1:0] forced to 0 before loading the PC.
- PC+4 wraps modulo 2^32; `32'hFFFF_FFFC` advances to `0`.
- IF/ID on a normal cycle loads `instrIF`, `pcIF+4`, and `validID=1`.
- IF/ID on a redirect (not held) loads `NOP_INSTR`, `pc4ID=0`, and `validID=0`. This is a single-slot flush of the wrong-path fetch.
- IF/ID with `IFIDhold` asserted keeps all of its fields.
- `PChold` and `IFIDhold` are acted on independently. The hazard unit drives them identically; the case where they differ is not required to be architecturally meaningful.

## Timing
- All state updates on the rising edge of `clk`. `pcIF` is a register output. The instruction path is combinational through the instruction memory.
- Latency: an instruction at `pcIF` in cycle n appears on `instrID` in cycle n+1.
- Redirect penalty: one bubble. The target is fetched in the cycle after the redirect edge.
- Hold for k cycles repeats the same `pcIF`/`instrID` for k extra cycles, with no lost or duplicated instruction.
- Reset is asynchronous. On assertion, immediately and in every case (including mid-stall or mid-redirect):
  - `pcIF=RESET_PC`
  - `instrID=NOP_INSTR`
  - `pc4ID=0`
  - `validID=0`
  - `holdCnt=0`
  - `flushCnt=0`
- First fetch after reset deasserts: the first rising edge latches `instrIF` at `RESET_PC`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `holdCnt` increments on each edge with `PChold`=1.
  - `flushCnt` increments on each redirect edge.
  - Both counters saturate at all-ones (no wrap) and clear only on reset.
- `FETCH_PERF_EN` undefined: the counter registers are not built; `holdCnt` and `flushCnt` are tied to 0. The ports remain present.

## Test plan
- Reset/sequential:
  - Stimulus: assert `reset` mid-cycle, then release it and run 4 cycles.
  - Required: `pcIF` reads 0, 4, 8, 12, 16. `instrID` follows the memory one cycle behind, `pc4ID` = 4, 8, 12, and `validID` = 0 then 1.
- Load-use hold:
  - Stimulus: `PChold`=`IFIDhold`=1 for 1 cycle at `pcIF`=8.
  - Required: `pcIF` reads 8 for two cycles, `instrID` (fetched from 4) is held one extra cycle, and the sequence then resumes with no skipped word. With the macro, `holdCnt`=1.
- Branch flush:
  - Stimulus: `branchID`=1 with `branchTarget`=`32'h40` at `pcIF`=12.
  - Required: next `pcIF`=`32'h40`, next `validID`=0 with `instrID`=`NOP_INSTR`, and the cycle after that `instrID`=mem[`32'h40`] with `validID`=1. `flushCnt`=1.
- Hold and jump together:
  - Stimulus: `jumpID`=1 with `jumpTarget`=`32'h103` while `PChold`=`IFIDhold`=1; the next cycle, `jumpID`=1 with no hold.
  - Required: the PC stays unchanged on the first edge, then becomes `32'h100` (low bits cleared). Exactly one bubble is inserted.
- Wrap and priority:
  - Stimulus: `pcIF`=`32'hFFFF_FFFC`, then `branchID`=`jumpID`=1 with different targets.
  - Required: the PC wraps to 0, and the jump target is taken.
- Saturation (`FETCH_PERF_EN`, `CNT_W`=4):
  - Stimulus: hold for 20 cycles.
  - Required: `holdCnt` stops at 15. An asynchronous `reset` mid-hold clears it to 0 immediately.
